fp16_accumulator: RTL and testbench

Downstream stage of `fp16_multiplier` in the NPU MAC datapath. It consumes each product using the multiplier's `valid`/`clear` handshake and sums the products into an fp16 accumulator. On a term flagged `prod_last` it presents the sum on `sum`/`sum_valid` and holds it until acknowledged. Each term is added in a fixed 4-cycle align/add/normalise sequence.

---
 rtl/npu_fp16_pkg.sv | 40 ++++
 rtl/fp16_lzc.sv | 15 +
 rtl/fp16_accumulator.sv | 175 +++++++++++++++++
 tb/tb_fp16_accumulator.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/npu_fp16_pkg.sv
// Shared fp16 definitions for the NPU MAC datapath: format constants,
// accumulator FSM states and the unpacked-operand view used for alignment.
package npu_fp16_pkg;

   localparam int          FP16_BIAS    = 15;
   localparam logic [15:0] FP16_MAX_FIN = 16'h7BFF;
   localparam int          FP16_EXP_W   = 5;
   localparam int          FP16_MAN_W   = 10;

   typedef enum logic [2:0] {
      IDLE,
      ALIGN,
      ADD,
      NORM,
      DONE
   } acc_state_t;

   typedef struct packed {
      logic                  sign;
      logic [FP16_EXP_W-1:0] expo;
      logic [FP16_MAN_W:0]   sig;   // hidden bit included
   } fp16_unp_t;

   // Exponent 0 flushes to zero; exponent 31 (inf/NaN) clamps to the largest finite magnitude.
   function automatic fp16_unp_t fp16_unpack(input logic [15:0] x);
      fp16_unp_t u;
      u.sign = x[15];
      u.expo = x[14:10];
      u.sig  = {1'b1, x[FP16_MAN_W-1:0]};
      if (x[14:10] == '0) begin
         u.expo = '0;
         u.sig  = '0;
      end else if (x[14:10] == '1) begin
         u.expo = FP16_EXP_W'(2 * FP16_BIAS);
         u.sig  = '1;
      end
      return u;
   endfunction

endpackage

// File: rtl/fp16_lzc.sv
// Combinational 12-bit leading-zero counter; all-zero input reports 12.
module fp16_lzc (
   input  logic [11:0] v,
   output logic [3:0]  cnt
);

   // Highest set bit wins because later loop iterations overwrite earlier ones.
   always_comb begin
      cnt = 4'd12;
      for (int i = 0; i < 12; i++) begin
         if (v[i]) cnt = 4'(11 - i);
      end
   end

endmodule

// File: rtl/fp16_accumulator.sv
// fp16 accumulator behind fp16_multiplier: each accepted product is folded
// into the running sum over a fixed ALIGN/ADD/NORM sequence; the last term
// presents the sum until the consumer acknowledges it.
module fp16_accumulator
   import npu_fp16_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset_b,
   input  logic             prod_valid,
   input  logic [15:0]      prod,
   input  logic             prod_last,
   output logic             prod_clear,
   output logic             sum_valid,
   output logic [15:0]      sum,
   output logic             sum_ovf,
   output logic [CNT_W-1:0] terms,
   input  logic             sum_clear
);

   acc_state_t        state_q;
   logic              last_q, clr_q, sv_q, ovf_q;
   logic [15:0]       acc_q, op_q;
   logic [CNT_W-1:0]  terms_q;

   // Alignment stage registers
   logic              sa_q, sb_q, inf_q;
   logic [10:0]       ma_q, mb_q;
   logic [4:0]        eref_q;
   // Add stage registers
   logic              sr_q;
   logic [11:0]       mag_q;

   fp16_unp_t         ua, ub;
   logic              sa_d, sb_d, inf_d, sr_d;
   logic [10:0]       ma_d, mb_d;
   logic [4:0]        eref_d, ediff_d;
   logic [11:0]       mag_d, m_n;
   logic [3:0]        lz;
   logic signed [6:0] e_n;
   logic [16:0]       res_n;   // {overflow, packed fp16}

   // Flush underflow to +0, saturate overflow to the largest finite value.
   function automatic logic [16:0] fp16_pack_sat(input logic s, input logic signed [6:0] e,
                                                 input logic [11:0] m);
      if (m == '0 || e <= 0) return 17'h0_0000;
      if (e >= 31)           return {1'b1, s, FP16_MAX_FIN[14:0]};
      return {1'b0, s, e[4:0], m[FP16_MAN_W-1:0]};
   endfunction

   assign ua    = fp16_unpack(acc_q);
   assign ub    = fp16_unpack(op_q);
   assign inf_d = (acc_q[14:10] == 5'h1F) || (op_q[14:10] == 5'h1F);

   // Align: larger exponent is the reference, the other significand is truncated right.
   always_comb begin
      sa_d    = ua.sign;
      sb_d    = ub.sign;
      ma_d    = ua.sig;
      mb_d    = ub.sig;
      eref_d  = ua.expo;
      ediff_d = '0;
      if (ua.expo >= ub.expo) begin
         ediff_d = ua.expo - ub.expo;
         mb_d    = (ediff_d >= 5'd12) ? '0 : (ub.sig >> ediff_d);
      end else begin
         eref_d  = ub.expo;
         ediff_d = ub.expo - ua.expo;
         ma_d    = (ediff_d >= 5'd12) ? '0 : (ua.sig >> ediff_d);
      end
   end

   // Add: sign-magnitude add or subtract; difference takes the larger operand's sign.
   always_comb begin
      sr_d  = sa_q;
      mag_d = {1'b0, ma_q} + {1'b0, mb_q};
      if (sa_q != sb_q) begin
         if (ma_q >= mb_q) begin
            mag_d = {1'b0, ma_q - mb_q};
         end else begin
            mag_d = {1'b0, mb_q - ma_q};
            sr_d  = sb_q;
         end
      end
   end

   fp16_lzc u_lzc (
      .v   (mag_q),
      .cnt (lz)
   );

   // Normalise: carry shifts right, otherwise move the leading one to the hidden-bit position.
   always_comb begin
      if (mag_q[11]) begin
         m_n = mag_q >> 1;
         e_n = $signed({2'b00, eref_q}) + 7'sd1;
      end else begin
         m_n = mag_q << (lz - 4'd1);
         e_n = $signed({2'b00, eref_q}) + 7'sd1 - $signed({3'b000, lz});
      end
      res_n = fp16_pack_sat(sr_q, e_n, m_n);
   end

   // Datapath stage registers, loaded only in the state that produces them.
   always_ff @(posedge clk) begin
      if (state_q == IDLE && prod_valid) op_q <= prod;
      if (state_q == ALIGN) begin
         sa_q   <= sa_d;
         sb_q   <= sb_d;
         ma_q   <= ma_d;
         mb_q   <= mb_d;
         eref_q <= eref_d;
         inf_q  <= inf_d;
      end
      if (state_q == ADD) begin
         sr_q  <= sr_d;
         mag_q <= mag_d;
      end
   end

   // Sequencing FSM with registered handshake outputs and accumulator state.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state_q <= IDLE;
         last_q  <= 1'b0;
         clr_q   <= 1'b0;
         sv_q    <= 1'b0;
         ovf_q   <= 1'b0;
         acc_q   <= '0;
         terms_q <= '0;
      end else begin
         clr_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (prod_valid) begin
                  last_q  <= prod_last;
                  clr_q   <= 1'b1;
                  state_q <= ALIGN;
               end
            end
            ALIGN: state_q <= ADD;
            ADD:   state_q <= NORM;
            NORM: begin
               acc_q   <= res_n[15:0];
               ovf_q   <= ovf_q | res_n[16] | inf_q;
               terms_q <= (terms_q == '1) ? terms_q : terms_q + 1'b1;
               if (last_q) begin
                  sv_q    <= 1'b1;
                  state_q <= DONE;
               end else begin
                  state_q <= IDLE;
               end
            end
            DONE: begin
               if (sum_clear) begin
                  acc_q   <= '0;
                  terms_q <= '0;
                  ovf_q   <= 1'b0;
                  sv_q    <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign prod_clear = clr_q;
   assign sum_valid  = sv_q;
   assign sum        = acc_q;
   assign sum_ovf    = ovf_q;
   assign terms      = terms_q;

endmodule

// File: tb/tb_fp16_accumulator.sv
// Scoreboard bench for fp16_accumulator: stimulus pushes hand-computed sums,
// a monitor pops and compares whenever sum_valid rises.
module tb_fp16_accumulator;

   typedef struct packed {
      logic [15:0] s;
      logic [7:0]  t;
      logic        o;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_b;
   logic        prod_valid;
   logic [15:0] prod;
   logic        prod_last;
   logic        prod_clear;
   logic        sum_valid;
   logic [15:0] sum;
   logic        sum_ovf;
   logic [7:0]  terms;
   logic        sum_clear;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   exp_t mon_e;
   logic sv_prev = 1'b0;

   fp16_accumulator #(.CNT_W(8)) dut (
      .clk        (clk),
      .reset_b    (reset_b),
      .prod_valid (prod_valid),
      .prod       (prod),
      .prod_last  (prod_last),
      .prod_clear (prod_clear),
      .sum_valid  (sum_valid),
      .sum        (sum),
      .sum_ovf    (sum_ovf),
      .terms      (terms),
      .sum_clear  (sum_clear)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // Monitor: compare the presented sum against the scoreboard on each rising sum_valid.
   always @(negedge clk) begin
      if (reset_b && sum_valid && !sv_prev) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected actual=%0h required=none", sum);
         end else begin
            mon_e = exp_q.pop_front();
            chk("sum", {16'h0, sum}, {16'h0, mon_e.s});
            chk("terms", {24'h0, terms}, {24'h0, mon_e.t});
            chk("ovf", {31'h0, sum_ovf}, {31'h0, mon_e.o});
         end
      end
      sv_prev = sum_valid;
   end

   task automatic expect_sum(input logic [15:0] s, input logic [7:0] t, input logic o);
      exp_t e;
      e.s = s;
      e.t = t;
      e.o = o;
      exp_q.push_back(e);
   endtask

   // Offer one product; returns after edge 3 of its accumulation.
   task automatic send_term(input logic [15:0] v, input logic last);
      bit got = 0;
      @(negedge clk);
      prod_valid = 1'b1;
      prod       = v;
      prod_last  = last;
      for (int n = 0; n < 20 && !got; n++) begin
         @(negedge clk);
         if (prod_clear) got = 1;
      end
      prod_valid = 1'b0;
      chk("ack_seen", {31'h0, got}, 32'h1);
      @(negedge clk);
      chk("ack_width", {31'h0, prod_clear}, 32'h0);
      @(negedge clk);
      chk("sv_early", {31'h0, sum_valid}, 32'h0);
      @(negedge clk);
      if (last) chk("sv_edge3", {31'h0, sum_valid}, 32'h1);
   endtask

   task automatic finish_sum();
      int n = 0;
      while (!sum_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("sv_seen", {31'h0, sum_valid}, 32'h1);
      sum_clear = 1'b1;
      @(negedge clk);
      sum_clear = 1'b0;
      chk("sv_drop", {31'h0, sum_valid}, 32'h0);
      chk("terms_clr", {24'h0, terms}, 32'h0);
      chk("ovf_clr", {31'h0, sum_ovf}, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit got;
      reset_b    = 1'b0;
      prod_valid = 1'b0;
      prod       = 16'h0;
      prod_last  = 1'b0;
      sum_clear  = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_sum", {16'h0, sum}, 32'h0);
      chk("rst_sv", {31'h0, sum_valid}, 32'h0);
      chk("rst_terms", {24'h0, terms}, 32'h0);
      chk("rst_clr", {31'h0, prod_clear}, 32'h0);
      reset_b = 1'b1;

      // 1.0 alone
      expect_sum(16'h3C00, 8'd1, 1'b0);
      send_term(16'h3C00, 1'b1);
      finish_sum();

      // 1.0 + 2.0, with a sum_clear in IDLE between terms that must be ignored
      expect_sum(16'h4200, 8'd2, 1'b0);
      send_term(16'h3C00, 1'b0);
      sum_clear = 1'b1;
      @(negedge clk);
      sum_clear = 1'b0;
      chk("idle_clr_terms", {24'h0, terms}, 32'h1);
      chk("idle_clr_sum", {16'h0, sum}, 32'h3C00);
      send_term(16'h4000, 1'b1);
      finish_sum();

      // 1.5 - 1.5 cancels to +0
      expect_sum(16'h0000, 8'd2, 1'b0);
      send_term(16'h3E00, 1'b0);
      send_term(16'hBE00, 1'b1);
      finish_sum();

      // Overflow saturates
      expect_sum(16'h7BFF, 8'd2, 1'b1);
      send_term(16'h7BFF, 1'b0);
      send_term(16'h7BFF, 1'b1);
      finish_sum();

      // Truncation of a far-smaller term
      expect_sum(16'h3C00, 8'd2, 1'b0);
      send_term(16'h3C00, 1'b0);
      send_term(16'h0C00, 1'b1);
      finish_sum();

      // Subnormal flushes to zero
      expect_sum(16'h3C00, 8'd2, 1'b0);
      send_term(16'h3C00, 1'b0);
      send_term(16'h0001, 1'b1);
      finish_sum();

      // -2.0 + 1.0 = -1.0
      expect_sum(16'hBC00, 8'd2, 1'b0);
      send_term(16'hC000, 1'b0);
      send_term(16'h3C00, 1'b1);
      finish_sum();

      // Infinity input clamps and flags overflow
      expect_sum(16'h7BFF, 8'd1, 1'b1);
      send_term(16'h7C00, 1'b1);
      finish_sum();

      // Reset during ADD of the second term
      send_term(16'h3C00, 1'b0);
      @(negedge clk);
      prod_valid = 1'b1;
      prod       = 16'h4000;
      prod_last  = 1'b1;
      got = 0;
      for (int n = 0; n < 20 && !got; n++) begin
         @(negedge clk);
         if (prod_clear) got = 1;
      end
      prod_valid = 1'b0;
      chk("ack2_seen", {31'h0, got}, 32'h1);
      @(negedge clk);
      reset_b = 1'b0;
      #1;
      chk("mid_rst_sum", {16'h0, sum}, 32'h0);
      chk("mid_rst_sv", {31'h0, sum_valid}, 32'h0);
      chk("mid_rst_terms", {24'h0, terms}, 32'h0);
      chk("mid_rst_ovf", {31'h0, sum_ovf}, 32'h0);
      chk("mid_rst_clr", {31'h0, prod_clear}, 32'h0);
      @(negedge clk);
      reset_b = 1'b1;
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         chk("post_rst_clr", {31'h0, prod_clear}, 32'h0);
         chk("post_rst_sv", {31'h0, sum_valid}, 32'h0);
      end

      // Fresh sequence after reset
      expect_sum(16'h3800, 8'd1, 1'b0);
      send_term(16'h3800, 1'b1);
      finish_sum();

      repeat (3) @(negedge clk);
      chk("sb_empty", exp_q.size(), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
